// File: rtl/line_memory_if.sv
// Request/response bus between the data cache's off-chip port and line_memory.
interface line_memory_if;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  modport master (output addr_i, data_i, enable_i, write_i, input ack_o, data_o);
  modport slave  (input addr_i, data_i, enable_i, write_i, output ack_o, data_o);
endinterface

// File: rtl/line_memory.sv
// Fixed-latency 256-bit line memory behind an enable/ack handshake.
// Optional read/write statistics counters: define LINE_MEMORY_STATS_EN.
module line_memory #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  line_memory_if.slave    bus
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [15:0]     rd_cnt_o,
  output logic [15:0]     wr_cnt_o
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        addr_r;
  logic               wr_r;
  logic [255:0]       wdata_r;
  logic               ack_r;
  logic [255:0]       rdata_r;
  logic [255:0]       mem_r [DEPTH] = '{default: 256'd0};

  logic               go_ack_s;
  logic [31:0]        acc_addr_s;
  logic               acc_wr_s;
  logic [255:0]       acc_data_s;
  logic               acc_in_s;
  logic [IDX_W-1:0]   acc_idx_s;

`ifdef LINE_MEMORY_STATS_EN
  logic [15:0]        rd_cnt_r;
  logic [15:0]        wr_cnt_r;
  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;
`endif

  assign bus.ack_o  = ack_r;
  assign bus.data_o = rdata_r;

  // Select the access to commit: live inputs when LATENCY=1 skips BUSY, else the latched request
  always_comb begin
    go_ack_s   = 1'b0;
    acc_addr_s = addr_r;
    acc_wr_s   = wr_r;
    acc_data_s = wdata_r;
    case (state_r)
      IDLE: begin
        go_ack_s   = bus.enable_i && (LATENCY == 1);
        acc_addr_s = bus.addr_i;
        acc_wr_s   = bus.write_i;
        acc_data_s = bus.data_i;
      end
      BUSY:    go_ack_s = (cnt_r <= CNT_W'(1));
      default: go_ack_s = 1'b0;
    endcase
    if ({1'b0, acc_addr_s} < (33'(DEPTH) * 33'd32)) begin
      acc_in_s = 1'b1;
    end else begin
      acc_in_s = 1'b0;
    end
    acc_idx_s = acc_addr_s[5 +: IDX_W];
  end

  // Request FSM, latency counter, registered ack/read data and statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= 32'd0;
      wr_r    <= 1'b0;
      wdata_r <= 256'd0;
      ack_r   <= 1'b0;
      rdata_r <= 256'd0;
`ifdef LINE_MEMORY_STATS_EN
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 1'b0;
          if (bus.enable_i) begin
            addr_r  <= bus.addr_i;
            wr_r    <= bus.write_i;
            wdata_r <= bus.data_i;
            cnt_r   <= CNT_W'(LATENCY - 1);
            state_r <= (LATENCY == 1) ? ACK : BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            cnt_r <= '0;
          end
          state_r <= go_ack_s ? ACK : BUSY;
        end
        ACK: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      if (go_ack_s) begin
        ack_r <= 1'b1;
        if (!acc_wr_s) begin
          rdata_r <= acc_in_s ? mem_r[acc_idx_s] : 256'd0;
        end
`ifdef LINE_MEMORY_STATS_EN
        if (acc_wr_s && (wr_cnt_r != 16'hFFFF)) begin
          wr_cnt_r <= wr_cnt_r + 16'd1;
        end
        if (!acc_wr_s && (rd_cnt_r != 16'hFFFF)) begin
          rd_cnt_r <= rd_cnt_r + 16'd1;
        end
`endif
      end
    end
  end

  // Line storage; deliberately not cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_ack_s && acc_wr_s && acc_in_s) begin
      mem_r[acc_idx_s] <= acc_data_s;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed table, handshake corner cases, random traffic vs. a line-array model.
module tb_line_memory;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;
  localparam int TMO     = 40;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
    logic [255:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  line_memory_if bus ();
`ifdef LINE_MEMORY_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  line_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef LINE_MEMORY_STATS_EN
    ,
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] model_mem [DEPTH];
  logic [255:0] model_last_rd = 256'd0;
  int exp_rd = 0;
  int exp_wr = 0;
  int cyc = 0;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Expected result of a request, from the line-array view of memory; also updates the model.
  task automatic model_req(input logic [31:0] a, input logic w, input logic [255:0] d);
    longint unsigned ua;
    ua = a;
    if (w) begin
      exp_wr++;
      if (ua < DEPTH * 32) model_mem[ua / 32] = d;
    end else begin
      exp_rd++;
      model_last_rd = (ua < DEPTH * 32) ? model_mem[ua / 32] : 256'd0;
    end
  endtask

  // Wait (bounded) for an ack; n = negedges waited.
  task automatic wait_ack(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < TMO);
    if (!bus.ack_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: ack timeout after %0d cycles", name, n);
    end
  endtask

  // Issue one request, return latency and data_o in the ack cycle; check single-cycle pulse.
  task automatic do_req(input string name, input logic [31:0] a, input logic w, input logic [255:0] d,
                        output logic [255:0] got, output int lat);
    @(negedge clk);
    bus.addr_i = a; bus.write_i = w; bus.data_i = d; bus.enable_i = 1'b1;
    wait_ack(name, lat);
    got = bus.data_o;
    bus.enable_i = 1'b0;
    bus.addr_i = $urandom; bus.data_i = rand_line();
    @(negedge clk);
    check({name, "_ack_pulse"}, {255'd0, bus.ack_o}, 256'd0);
    model_req(a, w, d);
  endtask

  initial begin
    vec_t tbl [7];
    logic [255:0] got;
    int lat, t1, t2, n;
    logic [31:0] a;
    logic w;
    logic [255:0] d;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 256'd0;
    bus.addr_i = 32'd0; bus.data_i = 256'd0; bus.enable_i = 1'b0; bus.write_i = 1'b0;

    tbl[0] = '{32'h0000_0040, 1'b1, {8{32'hDEADBEEF}}, 256'd0};
    tbl[1] = '{32'h0000_0040, 1'b0, 256'd0, {8{32'hDEADBEEF}}};
    tbl[2] = '{32'h0000_005C, 1'b0, 256'd0, {8{32'hDEADBEEF}}};
    tbl[3] = '{32'h0000_4000, 1'b0, 256'd0, 256'd0};
    tbl[4] = '{32'h0000_4000, 1'b1, {8{32'h1234_5678}}, 256'd0};
    tbl[5] = '{32'h0000_0000, 1'b0, 256'd0, 256'd0};
    tbl[6] = '{32'h0000_0060, 1'b1, {8{32'hA5A5_0F0F}}, 256'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ack", {255'd0, bus.ack_o}, 256'd0);
      check("idle_data", bus.data_o, 256'd0);
    end
`ifdef LINE_MEMORY_STATS_EN
    check("stats_reset", {224'd0, rd_cnt, wr_cnt}, 256'd0);
`endif

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].data, got, lat);
      check($sformatf("tbl%0d_lat", i), 256'(lat), 256'(LATENCY));
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
    end

    // Back-to-back reads with enable held, then drop enable mid-BUSY
    @(negedge clk);
    bus.addr_i = 32'h0000_0040; bus.write_i = 1'b0; bus.enable_i = 1'b1;
    wait_ack("b2b0", n); t1 = cyc;
    check("b2b0_data", bus.data_o, {8{32'hDEADBEEF}});
    for (int k = 1; k < 3; k++) begin
      wait_ack($sformatf("b2b%0d", k), n); t2 = cyc;
      check($sformatf("b2b%0d_gap", k), 256'(t2 - t1), 256'(LATENCY + 1));
      check($sformatf("b2b%0d_data", k), bus.data_o, {8{32'hDEADBEEF}});
      t1 = t2;
    end
    repeat (5) @(negedge clk);
    bus.enable_i = 1'b0;
    bus.addr_i = 32'h0000_0060;
    wait_ack("drop_en", n); t2 = cyc;
    check("drop_en_gap", 256'(t2 - t1), 256'(LATENCY + 1));
    check("drop_en_data", bus.data_o, {8{32'hDEADBEEF}});
    repeat (4) model_req(32'h0000_0040, 1'b0, 256'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.ack_o) n++;
    end
    check("no_extra_ack", 256'(n), 256'd0);

    // Reset 5 cycles into a write to 0x80
    @(negedge clk);
    bus.addr_i = 32'h0000_0080; bus.write_i = 1'b1; bus.data_i = {8{32'hFFFF_FFFF}}; bus.enable_i = 1'b1;
    repeat (5) @(negedge clk);
    bus.enable_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack", {255'd0, bus.ack_o}, 256'd0);
    check("rst_data", bus.data_o, 256'd0);
    model_last_rd = 256'd0; exp_rd = 0; exp_wr = 0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.ack_o) n++;
    end
    check("rst_no_ack", 256'(n), 256'd0);
    do_req("rd_0x80", 32'h0000_0080, 1'b0, 256'd0, got, lat);
    check("rd_0x80_data", got, 256'd0);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 32) + ($urandom & 32'h000F_FFFF);
      else a = ($urandom_range(0, 15) << 5) | ($urandom & 32'h1F);
      w = 1'($urandom_range(0, 1));
      d = rand_line();
      do_req($sformatf("rnd%0d", i), a, w, d, got, lat);
      check($sformatf("rnd%0d_lat", i), 256'(lat), 256'(LATENCY));
      check($sformatf("rnd%0d_data", i), got, model_last_rd);
    end

`ifdef LINE_MEMORY_STATS_EN
    check("stats_rd", 256'(rd_cnt), 256'(exp_rd));
    check("stats_wr", 256'(wr_cnt), 256'(exp_wr));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
